// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N-channel stream multiplexer with valid/ready
// handshakes. The channel is chosen either by an external Select (fixed mode)
// or by round-robin arbitration. Each accepted word passes through a single
// output register. There is no skid buffer, so InReady follows OutReady
// combinationally.
module stream_mux_rr #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       InValid,
    input  logic [CHANNELS*WIDTH-1:0] InData,
    output logic [CHANNELS-1:0]       InReady,
    input  logic                      Mode,
    input  logic [SELW-1:0]           Select,
    output logic                      OutValid,
    output logic [WIDTH-1:0]          OutData,
    output logic [SELW-1:0]           OutChannel,
    input  logic                      OutReady
);

    logic [SELW-1:0]  pointer;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  next_pointer;
    logic             grant_valid;
    logic             load_en;
    logic             transfer_in;
    logic [WIDTH-1:0] grant_data;

    // The register can take a new word when it is empty or being drained now.
    assign load_en     = !OutValid || OutReady;
    assign transfer_in = load_en && grant_valid;

    // Grant selection: fixed select or round-robin search starting at pointer.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        grant       = '0;
        grant_valid = 1'b0;
        if (!Mode) begin
            // Only indices below CHANNELS are visited, so an out-of-range
            // Select can never grant.
            for (int i = 0; i < CHANNELS; i++) begin
                if (SELW'(i) == Select && InValid[i]) begin
                    grant       = SELW'(i);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            // Walk offsets from farthest to nearest so the channel closest to
            // the pointer is the last (winning) assignment.
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                if (InValid[(int'(pointer) + k) % CHANNELS]) begin
                    grant       = SELW'((int'(pointer) + k) % CHANNELS);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // Data steering for the granted channel and the pointer successor.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SELW'(i) == grant) begin
                grant_data = InData[i*WIDTH +: WIDTH];
            end
        end
        next_pointer = (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
    end

    // One-hot ready toward the granted channel; all zero while stalled.
    always_comb begin
        InReady = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            InReady[i] = transfer_in && (SELW'(i) == grant);
        end
    end

    // Output register and round-robin pointer; reload and drain may coincide.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            OutValid   <= 1'b0;
            OutData    <= '0;
            OutChannel <= '0;
            pointer    <= '0;
        end else if (transfer_in) begin
            OutValid   <= 1'b1;
            OutData    <= grant_data;
            OutChannel <= grant;
            pointer    <= next_pointer;
        end else if (OutReady) begin
            OutValid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: directed vectors, expected output words pushed
// into a scoreboard queue by the stimulus and popped by an independent monitor.
module tb_stream_mux_rr;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    in_valid;
    logic [W-1:0]  din [4];
    logic [4*W-1:0] in_data;
    logic [3:0]    in_ready;
    logic          mode;
    logic [1:0]    sel;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    out_channel;
    logic          out_ready;

    // Second instance with three channels for the out-of-range select case.
    logic [2:0]    in_valid3;
    logic [3*W-1:0] in_data3;
    logic [2:0]    in_ready3;
    logic [1:0]    sel3;
    logic          out_valid3;
    logic [W-1:0]  out_data3;
    logic [1:0]    out_channel3;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [33:0] exp_q [$];

    assign in_data = {din[3], din[2], din[1], din[0]};

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .CHANNELS(4), .SELW(2)) dut (
        .clk(clk), .rst(rst),
        .InValid(in_valid), .InData(in_data), .InReady(in_ready),
        .Mode(mode), .Select(sel),
        .OutValid(out_valid), .OutData(out_data), .OutChannel(out_channel),
        .OutReady(out_ready)
    );

    stream_mux_rr #(.WIDTH(W), .CHANNELS(3), .SELW(2)) dut3 (
        .clk(clk), .rst(rst),
        .InValid(in_valid3), .InData(in_data3), .InReady(in_ready3),
        .Mode(1'b0), .Select(sel3),
        .OutValid(out_valid3), .OutData(out_data3), .OutChannel(out_channel3),
        .OutReady(1'b1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle with inputs already applied: check InReady mid-cycle and
    // record the word that is expected to be accepted at the coming edge.
    task automatic cycle(input string name, input logic [3:0] exp_ready,
                         input bit push, input logic [1:0] ch, input logic [W-1:0] data);
        @(negedge clk);
        check(name, {60'd0, in_ready}, {60'd0, exp_ready});
        if (push) exp_q.push_back({ch, data});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word leaving the output register must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL out_word: got %0h, expected nothing", {out_channel, out_data});
            end else begin
                check("out_word", {30'd0, out_channel, out_data}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 4'b0000;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b0;
        din[0]    = 32'h1111_1111;
        din[1]    = 32'h2222_2222;
        din[2]    = 32'hDEAD_BEEF;
        din[3]    = 32'h4444_4444;
        in_valid3 = 3'b000;
        in_data3  = {32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};
        sel3      = 2'd0;

        // Reset state
        #2;
        check("rst_out_valid",   {63'd0, out_valid}, 64'd0);
        check("rst_out_data",    {32'd0, out_data}, 64'd0);
        check("rst_out_channel", {62'd0, out_channel}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fixed mode, Select=2, all valid, full throughput
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        sel       = 2'd2;
        for (int i = 0; i < 4; i++) cycle("fixed_ready", 4'b0100, 1, 2'd2, 32'hDEAD_BEEF);
        in_valid = 4'b0000;
        cycle("drain_ready", 4'b0000, 0, 2'd0, '0);
        check("drain_out_valid", {63'd0, out_valid}, 64'd0);

        // Round-robin, all valid; pointer left at 3 by the fixed-mode grants
        mode     = 1'b1;
        in_valid = 4'b1111;
        cycle("rr_ready", 4'b1000, 1, 2'd3, 32'h4444_4444);
        cycle("rr_ready", 4'b0001, 1, 2'd0, 32'h1111_1111);
        cycle("rr_ready", 4'b0010, 1, 2'd1, 32'h2222_2222);
        cycle("rr_ready", 4'b0100, 1, 2'd2, 32'hDEAD_BEEF);
        cycle("rr_ready", 4'b1000, 1, 2'd3, 32'h4444_4444);
        cycle("rr_ready", 4'b0001, 1, 2'd0, 32'h1111_1111);
        cycle("rr_ready", 4'b0010, 1, 2'd1, 32'h2222_2222);

        // Fixed grant of channel 3 brings the pointer back to 0
        mode = 1'b0;
        sel  = 2'd3;
        cycle("fixed3_ready", 4'b1000, 1, 2'd3, 32'h4444_4444);

        // Round-robin sparse: 1, 3, 1
        mode     = 1'b1;
        in_valid = 4'b1010;
        cycle("sparse_ready", 4'b0010, 1, 2'd1, 32'h2222_2222);
        cycle("sparse_ready", 4'b1000, 1, 2'd3, 32'h4444_4444);
        cycle("sparse_ready", 4'b0010, 1, 2'd1, 32'h2222_2222);

        // Backpressure: load 12345678 from channel 0, then stall three cycles
        mode     = 1'b0;
        sel      = 2'd0;
        din[0]   = 32'h1234_5678;
        in_valid = 4'b0001;
        cycle("bp_load_ready", 4'b0001, 1, 2'd0, 32'h1234_5678);
        out_ready = 1'b0;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cycle("stall_ready", 4'b0000, 0, 2'd0, '0);
            check("stall_out_valid",   {63'd0, out_valid}, 64'd1);
            check("stall_out_data",    {32'd0, out_data}, {32'd0, 32'h1234_5678});
            check("stall_out_channel", {62'd0, out_channel}, 64'd0);
        end
        out_ready = 1'b1;
        cycle("unstall_ready", 4'b0010, 1, 2'd1, 32'h2222_2222);
        in_valid = 4'b0000;
        cycle("bp_drain_ready", 4'b0000, 0, 2'd0, '0);

        // Fixed Select=3 with channel 3 idle: no grant, register drains
        mode     = 1'b0;
        sel      = 2'd3;
        in_valid = 4'b1000;
        cycle("sel3_load_ready", 4'b1000, 1, 2'd3, 32'h4444_4444);
        in_valid = 4'b0111;
        cycle("sel3_idle_ready", 4'b0000, 0, 2'd0, '0);
        check("sel3_out_valid_fell", {63'd0, out_valid}, 64'd0);
        cycle("sel3_idle_ready", 4'b0000, 0, 2'd0, '0);
        check("sel3_out_valid_low", {63'd0, out_valid}, 64'd0);

        // Reset while a word is held under backpressure
        mode     = 1'b1;
        in_valid = 4'b0100;
        cycle("prerst_ready", 4'b0100, 1, 2'd2, 32'hDEAD_BEEF);
        out_ready = 1'b0;
        in_valid  = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid",   {63'd0, out_valid}, 64'd0);
        check("async_rst_out_data",    {32'd0, out_data}, 64'd0);
        check("async_rst_out_channel", {62'd0, out_channel}, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        din[0]    = 32'h1111_1111;
        cycle("post_rst_ready", 4'b0001, 1, 2'd0, 32'h1111_1111);
        cycle("post_rst_ready", 4'b0010, 1, 2'd1, 32'h2222_2222);
        in_valid = 4'b0000;
        cycle("final_drain_ready", 4'b0000, 0, 2'd0, '0);
        check("final_out_valid", {63'd0, out_valid}, 64'd0);

        // Three-channel instance: Select=3 is out of range and never grants
        in_valid3 = 3'b111;
        sel3      = 2'd0;
        @(negedge clk);
        check("c3_sel0_ready", {61'd0, in_ready3}, 64'd1);
        @(posedge clk);
        #1;
        check("c3_out_valid", {63'd0, out_valid3}, 64'd1);
        check("c3_out_data",  {32'd0, out_data3}, {32'd0, 32'hCCCC_0000});
        sel3 = 2'd3;
        @(negedge clk);
        check("c3_sel3_ready", {61'd0, in_ready3}, 64'd0);
        @(posedge clk);
        #1;
        check("c3_out_valid_fell", {63'd0, out_valid3}, 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
